k054539_bus_seq: RTL and testbench

//  Host-side bus sequencer for the 054539 CPU port. Queues register read/write

---
 rtl/k054539_bus_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_k054539_bus_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k054539_bus_seq.sv
// k054539_bus_seq
//   Host-side bus sequencer for the 054539 CPU port. Register read/write
//   requests are queued in a small FIFO and replayed one at a time as timed
//   NCS + NWR/NRD cycles on the chip pins. The strobe is stretched while the
//   chip holds PIN_WAIT low. If PIN_WAIT stays low too long, the access is
//   cut short and a sticky error flag is set.
//
// Ports
//   CLK, NRES           clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; req_ready = FIFO not full
//   req_rnw/addr/wdata  request contents (addr bit 8 is not used by the chip)
//   rd_valid/rd_data    one-cycle pulse carrying captured read data
//   busy                FIFO non-empty or an access in progress
//   err, err_clr        sticky WAIT-timeout flag and its clear
//   PIN_*, NCS/NWR/NRD  registered chip-side bus pins, strobes active low
module k054539_bus_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned T_SETUP    = 1,
    parameter int unsigned T_CS2STB   = 1,
    parameter int unsigned T_STB      = 8,
    parameter int unsigned T_HOLD     = 1,
    parameter int unsigned T_RECOV    = 2,
    parameter int unsigned WAIT_TO    = 64
) (
    input  logic       CLK,
    input  logic       NRES,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err,
    input  logic       err_clr,
    output logic [7:0] PIN_AB,
    output logic       PIN_AB09,
    output logic [7:0] PIN_DB_OUT,
    output logic       PIN_DB_OE,
    input  logic [7:0] PIN_DB_IN,
    output logic       NCS,
    output logic       NWR,
    output logic       NRD,
    input  logic       PIN_WAIT
);

    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned M0   = (T_SETUP > T_CS2STB) ? T_SETUP : T_CS2STB;
    localparam int unsigned M1   = (M0 > T_STB) ? M0 : T_STB;
    localparam int unsigned M2   = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int unsigned M3   = (M2 > T_RECOV) ? M2 : T_RECOV;
    localparam int unsigned CMAX = (M3 > WAIT_TO) ? M3 : WAIT_TO;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CS, S_STB, S_HOLD, S_RECOV
    } state_t;

    // ---------------- request FIFO ----------------
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          full, empty, push, pop;
    logic [17:0]   head;
    logic          addr8_unused;

    assign addr8_unused = req_addr[8];
    assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    // A push that coincides with a pop is accepted even at full: the level stays put.
    assign push      = req_valid && (!full || pop);
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {req_rnw, req_addr[9], req_addr[7:0], req_wdata};
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- access sequencer ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ext_q, ext_d;     // strobe is in its PIN_WAIT extension window
    logic          rnw_q, rnw_d;
    logic          err_set, rd_cap, leave;

    assign rnw_d = pop ? head[17] : rnw_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        pop     = 1'b0;
        err_set = 1'b0;
        rd_cap  = 1'b0;
        leave   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_CS;
                    cnt_d   = CW'(T_CS2STB - 1);
                end else cnt_d = cnt_q - CW'(1);
            end
            S_CS: begin
                if (cnt_q == '0) begin
                    state_d = S_STB;
                    cnt_d   = CW'(T_STB - 1);
                    ext_d   = 1'b0;
                end else cnt_d = cnt_q - CW'(1);
            end
            S_STB: begin
                // Base window first; once it expires the counter is reused to
                // bound the number of extra cycles granted to PIN_WAIT.
                if (!ext_q) begin
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                    else if (PIN_WAIT) leave = 1'b1;
                    else begin
                        ext_d = 1'b1;
                        cnt_d = CW'(WAIT_TO - 1);
                    end
                end else begin
                    if (PIN_WAIT) leave = 1'b1;
                    else if (cnt_q == '0) begin
                        leave   = 1'b1;
                        err_set = 1'b1;
                    end else cnt_d = cnt_q - CW'(1);
                end
                if (leave) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                    rd_cap  = rnw_q;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_RECOV;
                    cnt_d   = CW'(T_RECOV - 1);
                end else cnt_d = cnt_q - CW'(1);
            end
            S_RECOV: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_SETUP;
                        cnt_d   = CW'(T_SETUP - 1);
                    end else state_d = S_IDLE;
                end else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic       ncs_q, nwr_q, nrd_q, oe_q, ab09_q, rd_valid_q, err_q;
    logic [7:0] ab_q, db_q, rd_data_q;

    // Pin registers are driven from the next state so they change together with it.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ext_q      <= 1'b0;
            rnw_q      <= 1'b0;
            ab_q       <= '0;
            ab09_q     <= 1'b0;
            db_q       <= '0;
            oe_q       <= 1'b0;
            ncs_q      <= 1'b1;
            nwr_q      <= 1'b1;
            nrd_q      <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            rnw_q   <= rnw_d;
            if (pop) begin
                ab09_q <= head[16];
                ab_q   <= head[15:8];
                db_q   <= head[7:0];
            end
            ncs_q      <= !(state_d inside {S_CS, S_STB, S_HOLD});
            nwr_q      <= !(state_d == S_STB && !rnw_d);
            nrd_q      <= !(state_d == S_STB && rnw_d);
            oe_q       <= (state_d inside {S_SETUP, S_CS, S_STB, S_HOLD}) && !rnw_d;
            rd_valid_q <= rd_cap;
            if (rd_cap) rd_data_q <= PIN_DB_IN;
            if (err_clr)      err_q <= 1'b0;
            else if (err_set) err_q <= 1'b1;
        end
    end

    assign busy       = !empty || (state_q != S_IDLE);
    assign PIN_AB     = ab_q;
    assign PIN_AB09   = ab09_q;
    assign PIN_DB_OUT = db_q;
    assign PIN_DB_OE  = oe_q;
    assign NCS        = ncs_q;
    assign NWR        = nwr_q;
    assign NRD        = nrd_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_k054539_bus_seq.sv
// tb_k054539_bus_seq
//   Directed bench for k054539_bus_seq. Expected accesses (address, data,
//   direction, strobe length, spacing) are queued as requests are driven; a
//   negedge monitor pops and compares them as the strobes appear on the pins.
module tb_k054539_bus_seq;

    logic       CLK = 1'b0, NRES = 1'b0;
    logic       req_valid = 1'b0, req_rnw = 1'b0, err_clr = 1'b0, PIN_WAIT = 1'b1;
    logic [9:0] req_addr = '0;
    logic [7:0] req_wdata = '0, PIN_DB_IN = 8'hA5;
    logic       req_ready, rd_valid, busy, err, PIN_AB09, PIN_DB_OE, NCS, NWR, NRD;
    logic [7:0] rd_data, PIN_AB, PIN_DB_OUT;

    k054539_bus_seq #(.FIFO_DEPTH(4), .T_SETUP(1), .T_CS2STB(1), .T_STB(8),
                      .T_HOLD(1), .T_RECOV(2), .WAIT_TO(64)) dut (
        .CLK(CLK), .NRES(NRES), .req_valid(req_valid), .req_ready(req_ready),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err),
        .err_clr(err_clr), .PIN_AB(PIN_AB), .PIN_AB09(PIN_AB09),
        .PIN_DB_OUT(PIN_DB_OUT), .PIN_DB_OE(PIN_DB_OE), .PIN_DB_IN(PIN_DB_IN),
        .NCS(NCS), .NWR(NWR), .NRD(NRD), .PIN_WAIT(PIN_WAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rnw;
        logic [9:0]  addr;
        logic [7:0]  wdata;
        int unsigned len;   // expected strobe-low cycles
        int unsigned gap;   // expected cycles since previous strobe start, 0 = unchecked
    } acc_t;

    acc_t        exq[$];
    logic [7:0]  rdq[$];
    int unsigned n_vec = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rnw, input logic [9:0] a, input logic [7:0] d,
                        input int unsigned len, input int unsigned gap);
        acc_t e;
        e.rnw = rnw; e.addr = a; e.wdata = d; e.len = len; e.gap = gap;
        exq.push_back(e);
        if (rnw) rdq.push_back(PIN_DB_IN);
        req_valid = 1'b1; req_rnw = rnw; req_addr = a; req_wdata = d;
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge CLK);
        check(tag, busy, 1'b0);
    endtask

    // ---------------- pin monitor / scoreboard ----------------
    int unsigned cyc = 0, stb_len = 0, ncs_len = 0, last_start = 0;
    logic        in_stb = 1'b0, rdv_prev = 1'b0;
    acc_t        cur;

    always @(negedge CLK) begin
        logic stb;
        cyc++;
        stb = !NWR || !NRD;
        if (!NRES) begin
            in_stb   = 1'b0;
            ncs_len  = 0;
            rdv_prev = 1'b0;
        end else begin
            if (!in_stb && stb) begin
                check("sb_expected", exq.size() != 0, 1'b1);
                if (exq.size() != 0) begin
                    cur = exq[0];
                    check("strobe_dir", {NWR, NRD}, cur.rnw ? 2'b10 : 2'b01);
                    check("ab", PIN_AB, cur.addr[7:0]);
                    check("ab09", PIN_AB09, cur.addr[9]);
                    check("db_oe", PIN_DB_OE, !cur.rnw);
                    if (!cur.rnw) check("db_out", PIN_DB_OUT, cur.wdata);
                    check("ncs_lead", ncs_len, 1);
                    if (cur.gap != 0) check("access_gap", cyc - last_start, cur.gap);
                    last_start = cyc;
                    in_stb  = 1'b1;
                    stb_len = 1;
                end
            end else if (in_stb && stb) begin
                stb_len++;
                check("strobe_excl", NWR | NRD, 1'b1);
                check("ncs_enclose", NCS, 1'b0);
            end else if (in_stb && !stb) begin
                check("strobe_len", stb_len, cur.len);
                check("ncs_hold", NCS, 1'b0);
                check("rd_valid_hold", rd_valid, cur.rnw);
                void'(exq.pop_front());
                in_stb = 1'b0;
            end
            if (NCS) ncs_len = 0;
            else if (!stb) ncs_len++;
            if (rd_valid) begin
                check("rd_valid_pulse", rdv_prev, 1'b0);
                check("rd_expected", rdq.size() != 0, 1'b1);
                if (rdq.size() != 0) check("rd_data", rd_data, rdq.pop_front());
            end
            rdv_prev = rd_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge CLK);
        check("rst_ncs", NCS, 1'b1);
        check("rst_nwr", NWR, 1'b1);
        check("rst_nrd", NRD, 1'b1);
        check("rst_oe", PIN_DB_OE, 1'b0);
        check("rst_pins", {PIN_AB09, PIN_AB, PIN_DB_OUT}, 17'h0);
        check("rst_rd", {rd_valid, rd_data}, 9'h0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        NRES = 1'b1;
        @(negedge CLK);

        // Single write: push edge N, SETUP after N+1, NCS low after N+2, NWR N+3..N+11.
        push(1'b0, 10'h050, 8'h11, 8, 0);
        check("t1_ncs_n", NCS, 1'b1);
        @(negedge CLK);
        check("t1_setup_pins", {PIN_AB09, PIN_AB, PIN_DB_OUT, PIN_DB_OE}, {1'b0, 8'h50, 8'h11, 1'b1});
        check("t1_setup_ncs", NCS, 1'b1);
        @(negedge CLK);
        check("t1_cs", {NCS, NWR}, 2'b01);
        @(negedge CLK);
        check("t1_nwr_fall", NWR, 1'b0);
        repeat (7) @(negedge CLK);
        check("t1_nwr_last", NWR, 1'b0);
        @(negedge CLK);
        check("t1_hold", {NCS, NWR}, 2'b01);
        @(negedge CLK);
        check("t1_recov", {NCS, PIN_DB_OE}, 2'b10);
        wait_idle("t1_idle");

        // Three back-to-back writes, 13 cycles apart; idle after edge N+40.
        push(1'b0, 10'h050, 8'h11, 8, 0);
        push(1'b0, 10'h051, 8'h22, 8, 13);
        push(1'b0, 10'h210, 8'h55, 8, 13);
        repeat (37) @(negedge CLK);
        check("t2_busy_last_recov", busy, 1'b1);
        @(negedge CLK);
        check("t2_busy_drop", busy, 1'b0);
        check("t2_last_pins", {PIN_AB09, PIN_AB}, {1'b1, 8'h10});

        // Read with PIN_WAIT sampled low on 5 edges, the last 3 beyond the base window.
        push(1'b1, 10'h01A, 8'h00, 8 + 3, 0);
        for (int i = 0; i < 20 && NRD !== 1'b0; i++) @(negedge CLK);
        check("t3_nrd_seen", NRD, 1'b0);
        check("t3_oe", PIN_DB_OE, 1'b0);
        repeat (5) @(negedge CLK);
        PIN_WAIT = 1'b0;
        repeat (5) @(negedge CLK);
        PIN_WAIT = 1'b1;
        check("t3_nrd_stretched", NRD, 1'b0);
        wait_idle("t3_idle");
        check("t3_rd_data", rd_data, 8'hA5);
        check("t3_err", err, 1'b0);

        // WAIT stuck low: first access times out (8+64); FIFO fills behind it.
        PIN_WAIT = 1'b0;
        push(1'b0, 10'h0AA, 8'h3C, 8 + 64, 0);
        for (int i = 0; i < 20 && NWR !== 1'b0; i++) @(negedge CLK);
        check("t4_nwr_seen", NWR, 1'b0);
        push(1'b0, 10'h2B1, 8'h01, 8, 0);
        check("t5_ready1", req_ready, 1'b1);
        push(1'b0, 10'h0C2, 8'h02, 8, 0);
        check("t5_ready2", req_ready, 1'b1);
        push(1'b1, 10'h1D3, 8'h00, 8, 0);
        check("t5_ready3", req_ready, 1'b1);
        push(1'b0, 10'h2E4, 8'h04, 8, 0);
        check("t5_full", req_ready, 1'b0);
        // Fifth request while full with no pop: must be dropped.
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 10'h0F5; req_wdata = 8'h05;
        repeat (2) @(negedge CLK);
        check("t5_full_held", req_ready, 1'b0);
        check("t4_err_pending", err, 1'b0);
        begin
            acc_t g;
            g.rnw = 1'b0; g.addr = 10'h067; g.wdata = 8'h06; g.len = 8; g.gap = 0;
            exq.push_back(g);
            req_addr = 10'h067; req_wdata = 8'h06;
        end
        // Held until the pop of the second access, where push+pop happen together.
        for (int i = 0; i < 200 && PIN_AB !== 8'hB1; i++) @(negedge CLK);
        req_valid = 1'b0;
        PIN_WAIT  = 1'b1;
        check("t5_pop_seen", PIN_AB, 8'hB1);
        check("t5_full_after_pushpop", req_ready, 1'b0);
        check("t4_err_set", err, 1'b1);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("t4_err_clr", err, 1'b0);
        wait_idle("t5_idle");
        check("t5_sb_drained", exq.size(), 0);
        check("t5_rd_drained", rdq.size(), 0);

        // Reset in the middle of a write strobe with a second request queued.
        push(1'b0, 10'h033, 8'h77, 8, 0);
        push(1'b0, 10'h044, 8'h88, 8, 0);
        for (int i = 0; i < 20 && NWR !== 1'b0; i++) @(negedge CLK);
        check("t6_nwr_seen", NWR, 1'b0);
        @(negedge CLK);
        #2 NRES = 1'b0;
        #1;
        check("t6_strobes_high", {NCS, NWR, NRD}, 3'b111);
        check("t6_oe", PIN_DB_OE, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", req_ready, 1'b1);
        exq.delete();
        rdq.delete();
        repeat (2) @(negedge CLK);
        NRES = 1'b1;
        @(negedge CLK);
        check("t6_fifo_empty", busy, 1'b0);
        push(1'b0, 10'h2CC, 8'h99, 8, 0);
        wait_idle("t6_idle");
        check("t6_sb_drained", exq.size(), 0);
        check("t6_last_pins", {PIN_AB09, PIN_AB, PIN_DB_OUT}, {1'b1, 8'hCC, 8'h99});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
